// File: rtl/uart_telem_rcv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_telem_rcv : 8N1 UART receiver for the eBike telemetry line.           |
// | Optional stop-bit error output enabled by defining UART_RCV_FERR_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_telem_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
`ifdef UART_RCV_FERR_EN
  ,
  output logic       frm_err
`endif
);

  localparam logic [11:0] C_HALF_BIT = 12'(BAUD_DIV / 2);
  localparam logic [11:0] C_FULL_BIT = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rx_ff1_q, rx_s_q, rx_prev_q;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shft_q, shft_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        w_fall;
  logic        w_shift;
  logic        unused_shft0;

  assign w_fall       = rx_prev_q & ~rx_s_q;
  assign w_shift      = (state_q != IDLE) && (baud_cnt_q == 12'd0);
  // Bit 0 only ever falls off the end of the shifter.
  assign unused_shft0 = shft_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1_q  <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= RX;
      rx_s_q    <= rx_ff1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 4'd0;
      shft_q     <= 9'd0;
      rdy_q      <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shft_q     <= shft_d;
      rdy_q      <= rdy_d;
      rx_data_q  <= rx_data_d;
    end
  end

`ifdef UART_RCV_FERR_EN
  logic frm_err_q, frm_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    frm_err_d = frm_err_q;
    if (state_q == DATA && w_shift && bit_cnt_q == 4'd8) begin
      frm_err_d = ~rx_s_q;
    end
  end

  assign frm_err = frm_err_q;
`endif

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shft_d     = shft_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    if (clr_rdy) begin
      rdy_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (w_fall) begin
          state_d    = START;
          baud_cnt_d = C_HALF_BIT;
          bit_cnt_d  = 4'd0;
          rdy_d      = 1'b0;
        end
      end
      START: begin
        if (w_shift) begin
          // A line already back high at mid start bit was a glitch.
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            baud_cnt_d = C_FULL_BIT;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
      end
      DATA: begin
        if (w_shift) begin
          shft_d     = {rx_s_q, shft_q[8:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = C_FULL_BIT;
          if (bit_cnt_q == 4'd8) begin
            rx_data_d = shft_q[8:1];
            rdy_d     = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdy     = rdy_q;
  assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_telem_rcv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_telem_rcv : directed bench for uart_telem_rcv (fast and full baud).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_telem_rcv;

  localparam int C_BAUD      = 64;
  localparam int C_BAUD_FULL = 2604;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic       rdy;
  logic [7:0] rx_data;
  logic       rx_full = 1'b1;
  logic       rdy_full;
  logic [7:0] rx_data_full;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rise_cnt = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] got_q[$];

`ifdef UART_RCV_FERR_EN
  logic frm_err;
  logic frm_err_full;
`endif

  always #5 clk = ~clk;

  uart_telem_rcv #(.BAUD_DIV(C_BAUD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rdy     (rdy),
    .rx_data (rx_data)
`ifdef UART_RCV_FERR_EN
    ,
    .frm_err (frm_err)
`endif
  );

  uart_telem_rcv #(.BAUD_DIV(C_BAUD_FULL)) dut_full (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_full),
    .clr_rdy (rdy_full),
    .rdy     (rdy_full),
    .rx_data (rx_data_full)
`ifdef UART_RCV_FERR_EN
    ,
    .frm_err (frm_err_full)
`endif
  );

  // Records every rdy rising edge of the fast receiver with its byte.
  always @(negedge clk) begin
    if (rdy && !rdy_prev) begin
      got_q.push_back(rx_data);
      rise_cnt++;
    end
    rdy_prev = rdy;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit full);
    logic [9:0] f;
    int         baud;
    f    = {stop_b, b, 1'b0};
    baud = full ? C_BAUD_FULL : C_BAUD;
    for (int i = 0; i < 10; i++) begin
      if (full) rx_full = f[i];
      else      rx = f[i];
      wait_clk(baud);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rdy_full !== 1'b0) begin n_err++; $display("FAIL reset_rdy_full: got %b want 0", rdy_full); end
    n_cmp++; if (rx_data_full !== 8'h00) begin n_err++; $display("FAIL reset_data_full: got %h want 00", rx_data_full); end
    rst = 1'b0;
    wait_clk(5000);
    n_cmp++; if (rdy !== 1'b0 || rise_cnt != 0) begin n_err++; $display("FAIL idle_rdy: got rdy=%b rises=%0d want 0/0", rdy, rise_cnt); end
  endtask

  task automatic test_full_baud();
    int  n;
    bit  seen;
    bit  pulse_ok;
    n = 0; seen = 1'b0; pulse_ok = 1'b0;
    fork
      send_frame(8'hAA, 1'b1, 1'b1);
      begin
        while (!seen && n < 30000) begin
          wait_clk(1);
          n++;
          if (rdy_full) seen = 1'b1;
        end
        if (seen) begin
          n_cmp++; if (rx_data_full !== 8'hAA) begin n_err++; $display("FAIL full_data: got %h want aa", rx_data_full); end
          wait_clk(1);
          pulse_ok = (rdy_full === 1'b0);
        end
      end
    join
    n_cmp++; if (!seen || n < 24730 || n > 24746) begin n_err++; $display("FAIL full_latency: got %0d clk want about 24738", n); end
    n_cmp++; if (!pulse_ok) begin n_err++; $display("FAIL full_pulse: rdy not a 1-clk strobe"); end
  endtask

  task automatic test_frame_aa();
    send_frame(8'hAA, 1'b1, 1'b0);
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'hAA) begin n_err++; $display("FAIL aa_frame: got rdy=%b data=%h want 1/aa", rdy, rx_data); end
    wait_clk(50);
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rdy_hold: got %b want 1", rdy); end
    clr_rdy = 1'b1;
    wait_clk(1);
    clr_rdy = 1'b0;
    n_cmp++; if (rdy !== 1'b0 || rx_data !== 8'hAA) begin n_err++; $display("FAIL clr_rdy: got rdy=%b data=%h want 0/aa", rdy, rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'h55, 8'h0F, 8'hFF};
    got_q.delete();
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1, 1'b0);
    wait_clk(20);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > i) begin
        n_cmp++; if (got_q[i] !== exp[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_false_start();
    int r0;
    r0 = rise_cnt;
    rx = 1'b0;
    wait_clk(20);
    rx = 1'b1;
    wait_clk(200);
    n_cmp++; if (rise_cnt != r0 || rdy !== 1'b0) begin n_err++; $display("FAIL false_rdy: got rdy=%b rises=%0d want 0/%0d", rdy, rise_cnt, r0); end
    n_cmp++; if (rx_data !== 8'hFF) begin n_err++; $display("FAIL false_data: got %h want ff", rx_data); end
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'h3C) begin n_err++; $display("FAIL after_false: got rdy=%b data=%h want 1/3c", rdy, rx_data); end
  endtask

  task automatic test_rdy_hold_clear();
    logic mid_rdy;
    send_frame(8'h12, 1'b1, 1'b0);
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'h12) begin n_err++; $display("FAIL frame12: got rdy=%b data=%h want 1/12", rdy, rx_data); end
    mid_rdy = 1'bx;
    fork
      send_frame(8'h34, 1'b1, 1'b0);
      begin wait_clk(10); mid_rdy = rdy; end
    join
    n_cmp++; if (mid_rdy !== 1'b0) begin n_err++; $display("FAIL start_clears: got %b want 0", mid_rdy); end
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'h34) begin n_err++; $display("FAIL frame34: got rdy=%b data=%h want 1/34", rdy, rx_data); end
  endtask

  task automatic test_async_reset();
    int r0;
    rx = 1'b0;
    wait_clk(100);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (rdy !== 1'b0 || rx_data !== 8'h00) begin n_err++; $display("FAIL async_rst: got rdy=%b data=%h want 0/00", rdy, rx_data); end
    #2 rst = 1'b0;
    rx = 1'b1;
    wait_clk(2);
    r0 = rise_cnt;
    wait_clk(800);
    n_cmp++; if (rise_cnt != r0 || rx_data !== 8'h00) begin n_err++; $display("FAIL abort: got rises=%0d data=%h want %0d/00", rise_cnt, rx_data, r0); end
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'h5A) begin n_err++; $display("FAIL post_rst: got rdy=%b data=%h want 1/5a", rdy, rx_data); end
  endtask

`ifdef UART_RCV_FERR_EN
  task automatic test_ferr();
    send_frame(8'hC3, 1'b0, 1'b0);
    rx = 1'b1;
    wait_clk(10);
    n_cmp++; if (rdy !== 1'b1 || rx_data !== 8'hC3 || frm_err !== 1'b1) begin n_err++; $display("FAIL ferr_bad: got rdy=%b data=%h ferr=%b want 1/c3/1", rdy, rx_data, frm_err); end
    wait_clk(2 * C_BAUD);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clk(10);
    n_cmp++; if (rx_data !== 8'h5A || frm_err !== 1'b0) begin n_err++; $display("FAIL ferr_good: got data=%h ferr=%b want 5a/0", rx_data, frm_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_baud();
    test_frame_aa();
    test_back_to_back();
    test_false_start();
    test_rdy_hold_clear();
    test_async_reset();
`ifdef UART_RCV_FERR_EN
    test_ferr();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
